cpld_disp_arbiter: RTL
======================

// Module: cpld_disp_arbiter
// PURPOSE
//  Shares the CPLD LED/7-seg display link between N_REQ requesters (game core, score, debug).
//  Each requester asks for display ownership. Ownership is granted round-robin and changes only
//  at serial-frame boundaries, so a frame never carries mixed data.
//  Returns a frame-debounced copy of the switch word from the link, with a change pulse.
//  Sits between the requesters and the serial CPLD link block.
// PARAMETERS
//  N_REQ        3  number of requesters (2..8)
//  HOLD_FRAMES  4  minimum frames an owner keeps the display while others wait (>=1)
//  DEB_FRAMES   3  consecutive identical switch samples needed to accept a change (>=1)
// PORTS
//  clk       in   1          system clock
//  rst       in   1          synchronous reset, active-low
//  frame_ld  in   1          load strobe level from link; its rising edge = frame_tick
//  req       in   N_REQ      display request, level; bit i = requester i
//  gnt       out  N_REQ      one-hot grant, or all-zero
//  led_in    in   8*N_REQ    LED word per requester; bits [8i+7:8i] = requester i
//  seg0_in   in   4*N_REQ    low digit per requester; bits [4i+3:4i]
//  seg1_in   in   4*N_REQ    high digit per requester; bits [4i+3:4i]
//  led       out  8          LED word to link (registered)
//  seg0      out  4          low digit to link (registered)
//  seg1      out  4          high digit to link (registered)
//  sw_in     in   8          raw switch word from link
//  sw_out    out  8          debounced switch word
//  sw_chg    out  1          1-clk pulse when sw_out changes
// BEHAVIOUR
//  Reset (rst==0 at posedge clk):
//   - gnt=0, led=0, seg0=0, seg1=0, sw_out=0, sw_chg=0.
//   - rr pointer=0, hold_cnt=0, deb_cnt=0, state=IDLE.
//   - frame_ld history reg=1, so a level already high at release gives no tick.
//   - Reset mid-frame drops the current grant immediately.
//  frame_tick: frame_ld==1 && prev==0. Lasts exactly 1 clk. All decisions below happen only on frame_tick.
//  FSM:
//   - IDLE: gnt=0, outputs driven 0.
//     On tick with any req set -> OWN; winner = first set req at or after rr pointer, wrapping.
//   - OWN: hold_cnt counts ticks, saturating at HOLD_FRAMES. On tick:
//     * owner req==0 -> release now, regardless of hold_cnt.
//     * else if hold_cnt>=HOLD_FRAMES and another req set -> switch.
//     * else keep.
//   - Release or switch:
//     * rr pointer = owner+1 (mod N_REQ).
//     * Pick next winner from that pointer among set reqs, excluding the old owner if others exist.
//     * No req set -> IDLE.
//     * hold_cnt=0 on every new grant.
//  Timing: req is sampled in the tick cycle. gnt updates the clk after the tick.
//   led/seg0/seg1 = muxed owner data, registered, valid 1 clk after gnt and every clk thereafter.
//   Tick-to-data latency = 2 clk, well inside one frame.
//  Owner data is passed through continuously while owned (not frozen per frame).
//  A single requester may own the display indefinitely. A lone requester never loses the grant.
//  Debounce:
//   - On tick, compare sw_in with the previous tick sample.
//   - Equal -> deb_cnt++ (saturate at DEB_FRAMES). Differ -> deb_cnt=1 and store the sample.
//   - When deb_cnt reaches DEB_FRAMES and the sample != sw_out: sw_out=sample, sw_chg=1 for 1 clk.
//   - sw_chg never asserts twice for the same value.
//  Simultaneous events:
//   - Owner drop and other req on the same tick -> direct switch, no IDLE frame.
//   - Reset overrides everything.
// TESTING
//  T1 reset:
//   - rst=0 for 3 clk with frame_ld=1, then release.
//   - Outputs stay 0. No gnt until frame_ld falls and rises again.
//  T2 single owner:
//   - req=3'b010, led_in[15:8]=8'hA5.
//   - 1st tick -> gnt=3'b010 at +1 clk, led=8'hA5 at +2 clk. Owner held across 20 ticks.
//  T3 round-robin:
//   - req=3'b111 constant, HOLD_FRAMES=4.
//   - gnt sequence 001,010,100,001. Each owner held exactly 4 ticks.
//  T4 early release:
//   - Owner 0 drops req after 1 tick while req[2]=1.
//   - Next tick gnt=3'b100, no IDLE gap. Drop with no others -> gnt=0, led=0.
//  T5 debounce:
//   - sw_in 8'h00->8'h3C, bouncing 8'h3C/8'h00 on ticks 1-2, then stable.
//   - sw_out=8'h3C after 3 stable ticks. Exactly one sw_chg pulse.
//  T6 mid-op reset:
//   - rst=0 during OWN with sw_out=8'h3C.
//   - All outputs 0 next clk. Re-arbitration starts from requester 0.

Source files
------------

// File: rtl/cpld_disp_arbiter.sv
// cpld_disp_arbiter
//   Shares the CPLD LED/7-seg display link between N_REQ requesters. Ownership
//   is granted round-robin and only changes on a serial-frame boundary (rising
//   edge of frame_ld), so a frame never carries mixed data. Also returns a
//   frame-debounced copy of the switch word with a one-clock change pulse.
// Ports
//   clk, rst            : system clock, synchronous active-low reset
//   frame_ld            : link load strobe; its rising edge is the frame tick
//   req / gnt           : per-requester request level / one-hot grant
//   led_in/seg0_in/seg1_in : packed per-requester display data
//   led/seg0/seg1       : registered data for the link (0 while idle)
//   sw_in / sw_out      : raw / debounced switch word
//   sw_chg              : one-clock pulse when sw_out changes
module cpld_disp_arbiter #(
    parameter int N_REQ       = 3,
    parameter int HOLD_FRAMES = 4,
    parameter int DEB_FRAMES  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_ld,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    input  logic [8*N_REQ-1:0] led_in,
    input  logic [4*N_REQ-1:0] seg0_in,
    input  logic [4*N_REQ-1:0] seg1_in,
    output logic [7:0]         led,
    output logic [3:0]         seg0,
    output logic [3:0]         seg1,
    input  logic [7:0]         sw_in,
    output logic [7:0]         sw_out,
    output logic               sw_chg
);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int DW = $clog2(DEB_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_FRAMES);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   owner, owner_nx, rr_ptr, rr_nx, owner_p1;
    logic [HW-1:0]   hold_cnt, hold_nx, hold_inc;
    logic [N_REQ-1:0] own_mask;
    logic [IW:0]     pk;
    logic            ld_prev, tick, others;

    logic [7:0]      sw_smp, smp_nx;
    logic [DW-1:0]   deb_cnt, deb_nx;
    logic            accept;

    // First set request at or after 'start', wrapping. MSB = found flag.
    // Scanning downward lets the closest candidate overwrite the rest.
    function automatic logic [IW:0] pick(input logic [N_REQ-1:0] r,
                                         input logic [IW-1:0] start);
        logic [IW:0] res;
        int j;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N_REQ;
            if (r[j]) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    assign tick     = frame_ld & ~ld_prev;
    assign own_mask = N_REQ'(1) << owner;
    assign others   = |(req & ~own_mask);
    assign owner_p1 = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    // The current tick is counted before the switch decision, so an owner
    // keeps the display for exactly HOLD_FRAMES frames under contention.
    assign hold_inc = (hold_cnt >= HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    assign gnt      = (state == OWN) ? own_mask : '0;

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        hold_nx  = hold_cnt;
        pk       = '0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        pk       = pick(req, rr_ptr);
                        state_nx = OWN;
                        owner_nx = pk[IW-1:0];
                        hold_nx  = '0;
                    end
                end
                OWN: begin
                    hold_nx = hold_inc;
                    if (!req[owner] || (hold_inc >= HOLD_MAX && others)) begin
                        // Old owner is masked out; it is last in scan order
                        // anyway, and on a drop its request is already low.
                        rr_nx   = owner_p1;
                        pk      = pick(req & ~own_mask, owner_p1);
                        hold_nx = '0;
                        if (pk[IW]) owner_nx = pk[IW-1:0];
                        else        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        smp_nx = sw_smp;
        deb_nx = deb_cnt;
        if (tick) begin
            if (sw_in == sw_smp) begin
                deb_nx = (deb_cnt >= DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
            end else begin
                deb_nx = DW'(1);
                smp_nx = sw_in;
            end
        end
    end

    // Only a fresh value is accepted, so a held value never re-pulses.
    assign accept = tick && (deb_nx >= DEB_MAX) && (smp_nx != sw_out);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            ld_prev  <= 1'b1;
            led      <= '0;
            seg0     <= '0;
            seg1     <= '0;
            sw_smp   <= '0;
            deb_cnt  <= '0;
            sw_out   <= '0;
            sw_chg   <= 1'b0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_nx;
            hold_cnt <= hold_nx;
            ld_prev  <= frame_ld;
            // Live pass-through of the current owner's data, one clk behind gnt.
            if (state == OWN) begin
                led  <= led_in[8*owner +: 8];
                seg0 <= seg0_in[4*owner +: 4];
                seg1 <= seg1_in[4*owner +: 4];
            end else begin
                led  <= '0;
                seg0 <= '0;
                seg1 <= '0;
            end
            sw_smp  <= smp_nx;
            deb_cnt <= deb_nx;
            sw_chg  <= accept;
            if (accept) sw_out <= smp_nx;
        end
    end
endmodule
